// File: rtl/i2c_slave_fsm.sv
// rtl/i2c_slave_fsm.sv - I2C responder: START/STOP detect, 7-bit address match, byte rx/tx.
// Define I2C_SLAVE_CLK_STRETCH_EN to enable SCL stretching while waiting for tx_valid.
module i2c_slave_fsm #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b1011010,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_select,
  output logic       scl_stretch,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP, LOAD_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   flag_q, flag_d;
  logic                   rw_q, rw_d, busy_q, busy_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic                   sda_out_q, sda_out_d, sda_select_q, sda_select_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic                   load_req, load_msb;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic                   stretch_q, stretch_d;
`else
  logic                   unused_tx_valid;
  assign unused_tx_valid = tx_valid;
`endif

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

  // flag_q: ACK slot already driven (ADDR_ACK/WR_ACK), byte fully shifted out
  // (RD_DATA), or MSB must be driven as soon as data arrives (LOAD_WAIT).
  always_comb begin
    scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    flag_d       = flag_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_ready_d   = 1'b0;
    sda_out_d    = sda_out_q;
    sda_select_d = sda_select_q;
    load_req     = 1'b0;
    load_msb     = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    stretch_d    = rx_valid_q && (state_q == WR_ACK);
`endif

    case (state_q)
      ADDR: if (scl_rise) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rw_d = sda_s;
          if (shift_q[6:0] == SLAVE_ADDRESS) begin
            state_d = ADDR_ACK;
            busy_d  = 1'b1;
            flag_d  = 1'b0;
          end else begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end
        end
      end
      ADDR_ACK, WR_ACK: if (scl_fall) begin
        if (!flag_q) begin
          sda_select_d = 1'b0;
          sda_out_d    = 1'b0;
          flag_d       = 1'b1;
        end else begin
          sda_select_d = 1'b1;
          sda_out_d    = 1'b1;
          bit_cnt_d    = 3'd0;
          state_d      = WR_DATA;
          if (state_q == ADDR_ACK && rw_q) begin
            load_req = 1'b1;
            load_msb = 1'b1;
          end
        end
      end
      WR_DATA: if (scl_rise) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = {shift_q[6:0], sda_s};
          rx_valid_d = 1'b1;
          state_d    = WR_ACK;
          flag_d     = 1'b0;
        end
      end
      RD_DATA: if (scl_fall) begin
        if (flag_q) begin
          sda_select_d = 1'b1;
          sda_out_d    = 1'b1;
          state_d      = RD_ACK;
        end else begin
          sda_select_d = 1'b0;
          sda_out_d    = shift_q[7];
          shift_d      = {shift_q[6:0], 1'b0};
          bit_cnt_d    = bit_cnt_q + 3'd1;
          flag_d       = (bit_cnt_q == 3'd7);
        end
      end
      RD_ACK: if (scl_rise) begin
        if (!sda_s) load_req = 1'b1;
        else        state_d  = WAIT_STOP;
      end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      LOAD_WAIT: begin
        if (tx_valid) begin
          load_req = 1'b1;
          load_msb = flag_q;
        end else begin
          stretch_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // From ADDR_ACK the MSB goes out on the same fall that releases the ACK.
    if (load_req) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      if (!tx_valid) begin
        state_d   = LOAD_WAIT;
        flag_d    = load_msb;
        stretch_d = 1'b1;
      end else
`endif
      begin
        tx_ready_d = 1'b1;
        state_d    = RD_DATA;
        flag_d     = 1'b0;
        if (load_msb) begin
          sda_select_d = 1'b0;
          sda_out_d    = tx_data[7];
          shift_d      = {tx_data[6:0], 1'b0};
          bit_cnt_d    = 3'd1;
        end else begin
          shift_d   = tx_data;
          bit_cnt_d = 3'd0;
        end
      end
    end

    if (stop_det) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      flag_d    = 1'b0;
    end
    if (start_det || stop_det) begin
      sda_select_d = 1'b1;
      sda_out_d    = 1'b1;
      rx_valid_d   = 1'b0;
      tx_ready_d   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q      <= IDLE;
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      flag_q       <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      sda_out_q    <= 1'b1;
      sda_select_q <= 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_s;
      sda_prev_q   <= sda_s;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      flag_q       <= flag_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      sda_out_q    <= sda_out_d;
      sda_select_q <= sda_select_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_q    <= stretch_d;
`endif
    end
  end

  assign sda_out    = sda_out_q;
  assign sda_select = sda_select_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign rw         = rw_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_stretch = stretch_q;
`else
  assign scl_stretch = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb/tb_i2c_slave_fsm.sv - Randomized scoreboard bench for i2c_slave_fsm driven by a bit-level I2C master.
module tb_i2c_slave_fsm;

  localparam logic [6:0] SLAVE = 7'b1011010;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       tx_valid = 1'b1;
  logic [7:0] tx_data;
  logic       sda_out, sda_select, scl_stretch, rx_valid, tx_ready, busy, rw;
  logic [7:0] rx_data;
  logic       sda_bus, scl_bus;

  assign sda_bus = sda_m & (sda_select | sda_out);
  assign scl_bus = scl_m & ~scl_stretch;

  i2c_slave_fsm dut (
    .clk(clk), .rst_(rst_), .scl_in(scl_bus), .sda_in(sda_bus),
    .sda_out(sda_out), .sda_select(sda_select), .scl_stretch(scl_stretch),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         rx_seen = 0, txr_seen = 0, release_viol = 0;
  logic       expect_release = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected write bytes on rx_valid, advances the tx source on tx_ready.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_seen++;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%0h, expected no pulse at %0t", rx_data, $time);
      end else begin
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
    end
    if (tx_ready) begin
      txr_seen++;
      if (tx_src.size() > 0) void'(tx_src.pop_front());
    end
    tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'hA5;
    if (expect_release && !sda_select) release_viol++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1;
    repeat (3 * Q) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(nack, r);
  endtask

  // Reference: only SLAVE is acknowledged; writes deliver every byte in order,
  // reads return the offered bytes in order with one tx_ready per byte.
  task automatic do_frame(input logic [6:0] addr, input logic rd, input logic [7:0] data[$]);
    logic       ack, match;
    logic [7:0] b;
    int         rx0, tr0, v0, n;
    n     = data.size();
    match = (addr == SLAVE);
    rx0   = rx_seen;
    tr0   = txr_seen;
    v0    = release_viol;
    expect_release = !match;
    if (match && rd) foreach (data[i]) tx_src.push_back(data[i]);
    bus_start();
    write_byte({addr, rd}, ack);
    chk("addr_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
    if (match) begin
      chk("busy_active", {31'd0, busy}, 32'd1);
      chk("rw", {31'd0, rw}, {31'd0, rd});
    end
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        read_byte(i == n - 1, b);
        chk("rd_byte", {24'd0, b}, match ? {24'd0, data[i]} : 32'hFF);
      end else begin
        if (match) exp_rx.push_back(data[i]);
        write_byte(data[i], ack);
        chk("wr_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
      end
    end
    bus_stop();
    chk("rx_count", rx_seen - rx0, (match && !rd) ? n : 0);
    chk("tx_ready_count", txr_seen - tr0, (match && rd) ? n : 0);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("sda_released", {31'd0, sda_select}, 32'd1);
    chk("release_violations", release_viol - v0, 32'd0);
    chk("rx_queue_drained", exp_rx.size(), 32'd0);
    expect_release = 1'b0;
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] a, b;
    logic       ack, r;
    int         rx0, tr0, found, n;

    repeat (4) @(negedge clk);
    chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("rst_sda_select", {31'd0, sda_select}, 32'd1);
    chk("rst_scl_stretch", {31'd0, scl_stretch}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    rst_ = 1'b1;
    repeat (4) @(negedge clk);

    d.delete(); d.push_back(8'h57); d.push_back(8'hEA);
    do_frame(SLAVE, 1'b0, d);
    chk("rx_data_last", {24'd0, rx_data}, 32'hEA);

    d.delete(); d.push_back(8'hC3); d.push_back(8'h3C);
    do_frame(SLAVE, 1'b1, d);

    d.delete(); d.push_back(8'h11); d.push_back(8'h22);
    do_frame(7'h2A, 1'b0, d);

    // Partial write byte abandoned by a repeated START into a read.
    rx0 = rx_seen;
    tr0 = txr_seen;
    bus_start();
    write_byte({SLAVE, 1'b0}, ack);
    chk("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) bus_bit(i % 2 == 0, r);
    tx_src.push_back(8'h96);
    bus_start();
    write_byte({SLAVE, 1'b1}, ack);
    chk("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
    chk("rs_rw", {31'd0, rw}, 32'd1);
    read_byte(1'b1, b);
    chk("rs_rd_byte", {24'd0, b}, 32'h96);
    bus_stop();
    chk("rs_no_rx", rx_seen - rx0, 32'd0);
    chk("rs_tx_ready", txr_seen - tr0, 32'd1);

    // Reset while the address ACK is being driven.
    a = {SLAVE, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(a[i], r);
    found = 0;
    for (int k = 0; k < 64 && found == 0; k++) begin
      if (!sda_select) found = 1;
      else @(negedge clk);
    end
    chk("ack_driven_before_reset", found, 32'd1);
    rst_ = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_sda_select", {31'd0, sda_select}, 32'd1);
    chk("mid_rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    wait_q();
    bus_stop();

    for (int t = 0; t < 20; t++) begin
      logic [6:0] ad;
      logic       rdb;
      ad  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLAVE;
      rdb = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(8'($urandom));
      do_frame(ad, rdb, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
